vx_dcache_share_sched: RTL and testbench
========================================

Name: vx_dcache_share_sched

Overview:
Round-robin scheduler that shares one core dcache request/response port between NUM_REQS requesters (LSU, texture unit, future units). It sits in the execute stage between the units and the dcache. Each read is tagged with its requester index, and each dcache response is routed back by that index. Per-requester outstanding-read counters throttle requesters at MAX_PENDING.

Parameters:
NUM_REQS, 2, number of requesters; power of two, ≥2
LANES, 4, lanes per request (NUM_THREADS)
WORD_SIZE, 4, bytes per lane word
ADDR_WIDTH, 30, word address width per lane
TAG_IN_WIDTH, 8, requester tag width
MAX_PENDING, 16, max outstanding reads per requester
(derived) SEL_BITS = log2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH+SEL_BITS; DW = WORD_SIZE*8

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid_in  in  NUM_REQS  per-requester request valid
req_rw_in  in  NUM_REQS  1=write, 0=read
req_tmask_in  in  NUM_REQS*LANES  active lanes
req_byteen_in  in  NUM_REQS*LANES*WORD_SIZE  byte enables
req_addr_in  in  NUM_REQS*LANES*ADDR_WIDTH  lane addresses
req_data_in  in  NUM_REQS*LANES*DW  write data
req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  requester tag
req_ready_in  out  NUM_REQS  per-requester accept
req_valid_out/req_rw_out/req_tmask_out/req_byteen_out/req_addr_out/req_data_out  out  1/1/LANES/LANES*WORD_SIZE/LANES*ADDR_WIDTH/LANES*DW  dcache request
req_tag_out  out  TAG_OUT_WIDTH  {tag_in, sel}; sel in LSBs
req_ready_out  in  1  dcache accepts
rsp_valid_in  in  1  dcache response valid
rsp_tmask_in  in  LANES  response lanes
rsp_data_in  in  LANES*DW  read data
rsp_tag_in  in  TAG_OUT_WIDTH  returned tag
rsp_ready_in  out  1  scheduler accepts response
rsp_valid_out  out  NUM_REQS  routed response valid
rsp_tmask_out/rsp_data_out/rsp_tag_out  out  NUM_REQS*LANES / NUM_REQS*LANES*DW / NUM_REQS*TAG_IN_WIDTH  routed response
rsp_ready_out  in  NUM_REQS  requester accepts response
idle  out  1  no buffered request/response, all counters zero

Behaviour:
- Reset (async): rr_ptr=0, req stage empty, rsp stage empty, all pend_cnt=0; req_valid_out=0, rsp_valid_out=0, all data/tag outputs 0, idle=1.
- Eligibility: elig[i] = req_valid_in[i] && (req_rw_in[i] || pend_cnt[i] < MAX_PENDING). Writes produce no dcache response and are never throttled.
- Arbitration: round-robin over elig. Search starts at rr_ptr, ascending, with wrap. On accept of index g, rr_ptr <= (g+1) mod NUM_REQS. rr_ptr is unchanged when nothing is accepted.
- Request stage: one pipe register. can_acc = !req_valid_out || req_ready_out.
- req_ready_in = one-hot grant gated by can_acc. This is combinational; no ready-to-valid loop exists, because grant depends only on valid, counters and rr_ptr.
- Request latency: accepted in cycle N, presented at req_valid_out in N+1. Full throughput: 1 request/cycle while req_ready_out=1.
- Request outputs hold stable while req_valid_out && !req_ready_out.
- Tag: req_tag_out = {req_tag_in[g], g[SEL_BITS-1:0]}.
- Response stage: one pipe register. sel = rsp_tag_in[SEL_BITS-1:0], latched with data.
- rsp_ready_in = !rsp_v_q || rsp_ready_out[sel_q]. Latency 1 cycle.
- Only rsp_valid_out[sel_q] is asserted. Each requester's tmask/data/tag lanes carry the latched value (broadcast); consumers qualify by their valid bit.
- Counters: pend_cnt[i] += 1 when a read from i is accepted into the request stage. pend_cnt[i] -= 1 on rsp_valid_out[i] && rsp_ready_out[i]. Both in the same cycle leaves the count unchanged.
- Counter width is log2(MAX_PENDING)+1, so it never wraps. Underflow (response for i with pend_cnt[i]==0) is a protocol error: assertion fires, counter saturates at 0.
- A requester at MAX_PENDING is skipped and the pointer search continues to the others. Its reads resume the cycle after a response handshake lowers its count.
- idle = !req_valid_out && !rsp_v_q && all pend_cnt==0.
- Reset mid-operation clears all buffered requests, responses and counters. The dcache must be reset in the same domain, so no stale responses arrive.

Test Plan:
- Both requesters issue reads continuously, req_ready_out=1: grants alternate 0,1,0,1. req_tag_out LSB alternates. One request/cycle after 1-cycle latency.
- Only requester 1 valid, rr_ptr=0: granted next cycle. rr_ptr becomes 0 (wrap). req_tag_out = {tag,1'b1}.
- req_ready_out=0 for 3 cycles while holding: req_valid_out stays 1 with identical outputs. req_ready_in=0 for all requesters. The held request is accepted on the cycle ready rises.
- Requester 0 issues 16 reads with no responses (MAX_PENDING=16): 17th read is stalled while requester 1 reads proceed. One response to requester 0 → its next read is granted the following cycle.
- Response tag sel=1 with rsp_ready_out[1]=0: rsp_valid_out=2'b10 and is held; rsp_ready_in=0. On release, pend_cnt[1] decrements by 1.
- Assert reset with requests buffered and counters nonzero: all outputs drop to 0 immediately and idle=1. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/vx_dcache_share_sched.sv
// vx_dcache_share_sched
// Round-robin share of one dcache request/response port between NUM_REQS
// requesters. Reads are tagged {tag_in, sel}. Responses are routed back by sel.
// Each requester's outstanding reads are limited to MAX_PENDING.
// Ports:
//   req_*_in       requester-side request bundles, packed per requester
//   req_ready_in   per-requester accept (one-hot grant)
//   req_*_out      registered dcache request, accepted on req_ready_out
//   rsp_*_in       dcache response, accepted on rsp_ready_in
//   rsp_*_out      registered response; valid is one-hot, payload is broadcast
//   idle           nothing buffered and no reads outstanding
module vx_dcache_share_sched #(
  parameter int NUM_REQS     = 2,
  parameter int LANES        = 4,
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_PENDING  = 16,
  localparam int SEL_BITS      = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
  localparam int DW            = WORD_SIZE * 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQS-1:0]                   req_valid_in,
  input  logic [NUM_REQS-1:0]                   req_rw_in,
  input  logic [NUM_REQS*LANES-1:0]             req_tmask_in,
  input  logic [NUM_REQS*LANES*WORD_SIZE-1:0]   req_byteen_in,
  input  logic [NUM_REQS*LANES*ADDR_WIDTH-1:0]  req_addr_in,
  input  logic [NUM_REQS*LANES*DW-1:0]          req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]      req_tag_in,
  output logic [NUM_REQS-1:0]                   req_ready_in,
  output logic                                  req_valid_out,
  output logic                                  req_rw_out,
  output logic [LANES-1:0]                      req_tmask_out,
  output logic [LANES*WORD_SIZE-1:0]            req_byteen_out,
  output logic [LANES*ADDR_WIDTH-1:0]           req_addr_out,
  output logic [LANES*DW-1:0]                   req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]              req_tag_out,
  input  logic                                  req_ready_out,
  input  logic                                  rsp_valid_in,
  input  logic [LANES-1:0]                      rsp_tmask_in,
  input  logic [LANES*DW-1:0]                   rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]              rsp_tag_in,
  output logic                                  rsp_ready_in,
  output logic [NUM_REQS-1:0]                   rsp_valid_out,
  output logic [NUM_REQS*LANES-1:0]             rsp_tmask_out,
  output logic [NUM_REQS*LANES*DW-1:0]          rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]      rsp_tag_out,
  input  logic [NUM_REQS-1:0]                   rsp_ready_out,
  output logic                                  idle
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  logic [SEL_BITS-1:0]     rr_ptr;
  logic [CNT_W-1:0]        pend_cnt [NUM_REQS];
  logic [NUM_REQS-1:0]     elig;
  logic [NUM_REQS-1:0]     grant_oh;
  logic [NUM_REQS-1:0]     inc;
  logic [NUM_REQS-1:0]     dec;
  logic [SEL_BITS-1:0]     grant_idx;
  logic [SEL_BITS-1:0]     cand;
  logic                    grant_found;
  logic                    can_acc;
  logic                    req_fire;

  logic                    rsp_v_q;
  logic [SEL_BITS-1:0]     sel_q;
  logic [LANES-1:0]        rsp_tmask_q;
  logic [LANES*DW-1:0]     rsp_data_q;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_q;
  logic                    rsp_fire;

  // Writes bypass the pending limit since they never return a response.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      elig[i] = req_valid_in[i] && (req_rw_in[i] || (pend_cnt[i] < CNT_W'(MAX_PENDING)));
    end
  end

  // First eligible requester at or after rr_ptr; NUM_REQS is a power of two so the sum wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = rr_ptr + SEL_BITS'(k);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_acc  = !req_valid_out || req_ready_out;
  assign req_fire = can_acc && grant_found;

  always_comb begin
    grant_oh = '0;
    if (req_fire) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready_in = grant_oh;
  assign inc          = grant_oh & ~req_rw_in;
  assign dec          = rsp_valid_out & rsp_ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      req_valid_out  <= 1'b0;
      req_rw_out     <= 1'b0;
      req_tmask_out  <= '0;
      req_byteen_out <= '0;
      req_addr_out   <= '0;
      req_data_out   <= '0;
      req_tag_out    <= '0;
    end else if (req_fire) begin
      rr_ptr         <= grant_idx + SEL_BITS'(1);
      req_valid_out  <= 1'b1;
      req_rw_out     <= req_rw_in[grant_idx];
      req_tmask_out  <= req_tmask_in[grant_idx*LANES +: LANES];
      req_byteen_out <= req_byteen_in[grant_idx*LANES*WORD_SIZE +: LANES*WORD_SIZE];
      req_addr_out   <= req_addr_in[grant_idx*LANES*ADDR_WIDTH +: LANES*ADDR_WIDTH];
      req_data_out   <= req_data_in[grant_idx*LANES*DW +: LANES*DW];
      req_tag_out    <= {req_tag_in[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
    end else if (req_ready_out) begin
      req_valid_out  <= 1'b0;
    end
  end

  assign rsp_ready_in = !rsp_v_q || rsp_ready_out[sel_q];
  assign rsp_fire     = rsp_valid_in && rsp_ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_v_q     <= 1'b0;
      sel_q       <= '0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else if (rsp_fire) begin
      rsp_v_q     <= 1'b1;
      sel_q       <= rsp_tag_in[SEL_BITS-1:0];
      rsp_tmask_q <= rsp_tmask_in;
      rsp_data_q  <= rsp_data_in;
      rsp_tag_q   <= rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];
    end else if (rsp_v_q && rsp_ready_out[sel_q]) begin
      rsp_v_q     <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    if (rsp_v_q) rsp_valid_out[sel_q] = 1'b1;
  end

  assign rsp_tmask_out = {NUM_REQS{rsp_tmask_q}};
  assign rsp_data_out  = {NUM_REQS{rsp_data_q}};
  assign rsp_tag_out   = {NUM_REQS{rsp_tag_q}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) pend_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (inc[i] && !dec[i]) begin
          pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && (pend_cnt[i] != '0)) begin
          pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    idle = !req_valid_out && !rsp_v_q;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (pend_cnt[i] != '0) idle = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_underflow_chk
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
      !(dec[gi] && (pend_cnt[gi] == '0)));
  end

endmodule

// File: tb/tb_vx_dcache_share_sched.sv
module tb_vx_dcache_share_sched;

  localparam int N   = 2;
  localparam int L   = 4;
  localparam int WS  = 4;
  localparam int AW  = 30;
  localparam int TW  = 8;
  localparam int MP  = 16;
  localparam int SB  = 1;
  localparam int TOW = TW + SB;
  localparam int DW  = WS * 8;
  localparam int BW  = L * WS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]      req_valid_in, req_rw_in, req_ready_in;
  logic [N*L-1:0]    req_tmask_in;
  logic [N*BW-1:0]   req_byteen_in;
  logic [N*L*AW-1:0] req_addr_in;
  logic [N*L*DW-1:0] req_data_in;
  logic [N*TW-1:0]   req_tag_in;
  logic              req_valid_out, req_rw_out, req_ready_out;
  logic [L-1:0]      req_tmask_out;
  logic [BW-1:0]     req_byteen_out;
  logic [L*AW-1:0]   req_addr_out;
  logic [L*DW-1:0]   req_data_out;
  logic [TOW-1:0]    req_tag_out;
  logic              rsp_valid_in, rsp_ready_in;
  logic [L-1:0]      rsp_tmask_in;
  logic [L*DW-1:0]   rsp_data_in;
  logic [TOW-1:0]    rsp_tag_in;
  logic [N-1:0]      rsp_valid_out, rsp_ready_out;
  logic [N*L-1:0]    rsp_tmask_out;
  logic [N*L*DW-1:0] rsp_data_out;
  logic [N*TW-1:0]   rsp_tag_out;
  logic              idle;

  vx_dcache_share_sched #(
    .NUM_REQS(N), .LANES(L), .WORD_SIZE(WS), .ADDR_WIDTH(AW),
    .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_tmask_in(req_tmask_in),
    .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_tmask_out(req_tmask_out),
    .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out), .idle(idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pointer, outstanding-read counts, expected stage contents.
  int               m_ptr;
  int               m_cnt [N];
  bit               e_rv, e_rw, e_sv;
  int               e_ssel;
  logic [L-1:0]     e_tmask, e_stmask;
  logic [BW-1:0]    e_byteen;
  logic [L*AW-1:0]  e_addr;
  logic [L*DW-1:0]  e_data, e_sdata;
  logic [TOW-1:0]   e_tag;
  logic [TW-1:0]    e_stag;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid_in[i] && (req_rw_in[i] || m_cnt[i] < MP)) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready_in();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if ((!e_rv || req_ready_out) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit m_idle();
    bit r;
    r = !e_rv && !e_sv;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) r = 0;
    return r;
  endfunction

  function automatic logic [N-1:0] m_rsp_valid();
    logic [N-1:0] r;
    r = '0;
    if (e_sv) r[e_ssel] = 1'b1;
    return r;
  endfunction

  // Advances the model with the inputs present now, then crosses one clock edge.
  task automatic tick();
    int g;
    bit acc, dec, rrdy;
    int dsel;
    g    = m_grant();
    acc  = (!e_rv || req_ready_out) && g >= 0;
    dec  = e_sv && rsp_ready_out[e_ssel];
    rrdy = !e_sv || rsp_ready_out[e_ssel];
    dsel = e_ssel;
    if (acc) begin
      e_rv     = 1;
      e_rw     = req_rw_in[g];
      e_tmask  = req_tmask_in[g*L +: L];
      e_byteen = req_byteen_in[g*BW +: BW];
      e_addr   = req_addr_in[g*L*AW +: L*AW];
      e_data   = req_data_in[g*L*DW +: L*DW];
      e_tag    = {req_tag_in[g*TW +: TW], SB'(g)};
      m_ptr    = (g + 1) % N;
      if (!req_rw_in[g]) m_cnt[g]++;
    end else if (req_ready_out) begin
      e_rv = 0;
    end
    if (dec && m_cnt[dsel] > 0) m_cnt[dsel]--;
    if (rsp_valid_in && rrdy) begin
      e_sv     = 1;
      e_ssel   = int'(rsp_tag_in[SB-1:0]);
      e_stmask = rsp_tmask_in;
      e_sdata  = rsp_data_in;
      e_stag   = rsp_tag_in[TOW-1:SB];
    end else if (dec) begin
      e_sv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req_fields();
    for (int i = 0; i < N; i++) begin
      req_tag_in[i*TW +: TW]    = TW'($urandom);
      req_tmask_in[i*L +: L]    = L'($urandom);
      req_byteen_in[i*BW +: BW] = BW'($urandom);
      for (int j = 0; j < L; j++) begin
        req_addr_in[(i*L+j)*AW +: AW] = AW'($urandom);
        req_data_in[(i*L+j)*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic rand_rsp_fields();
    rsp_tmask_in = L'($urandom);
    for (int j = 0; j < L; j++) rsp_data_in[j*DW +: DW] = $urandom;
  endtask

  task automatic do_reset();
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_tag_in    = '0;
    rsp_ready_out = '1;
    rand_req_fields();
    rand_rsp_fields();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0;
    m_cnt = '{default: 0};
    e_rv  = 0;
    e_sv  = 0;
    e_ssel = 0;
  endtask

  task automatic test_reset();
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_ready_out = '1;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (req_valid_out !== 1'b0 || req_tag_out !== '0 || req_addr_out !== '0 ||
        req_data_out !== '0 || req_tmask_out !== '0 || req_byteen_out !== '0 || req_rw_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_req_out valid=%b tag=%h exp all zero", req_valid_out, req_tag_out);
    end
    tests++;
    if (rsp_valid_out !== '0 || rsp_tag_out !== '0 || rsp_data_out !== '0 || rsp_tmask_out !== '0) begin
      fails++;
      $display("FAIL reset_rsp_out valid=%b tag=%h exp all zero", rsp_valid_out, rsp_tag_out);
    end
    tests++;
    if (idle !== 1'b1 || req_ready_in !== '0 || rsp_ready_in !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags idle=%b req_ready_in=%b rsp_ready_in=%b exp 1/00/1",
               idle, req_ready_in, rsp_ready_in);
    end
    do_reset();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_valid_in = '1;
      req_rw_in    = '0;
      rand_req_fields();
      #1;
      tests++;
      if (req_ready_in !== N'(1 << (k % 2))) begin
        fails++;
        $display("FAIL alt_grant cyc=%0d got=%b exp=%b", k, req_ready_in, N'(1 << (k % 2)));
      end
      tick();
      tests++;
      if (req_valid_out !== 1'b1 || req_tag_out !== e_tag || req_addr_out !== e_addr ||
          req_data_out !== e_data || req_tmask_out !== e_tmask || req_byteen_out !== e_byteen ||
          req_tag_out[0] !== 1'(k % 2)) begin
        fails++;
        $display("FAIL alt_out cyc=%0d valid=%b tag=%h exp valid=1 tag=%h", k, req_valid_out, req_tag_out, e_tag);
      end
    end
  endtask

  task automatic test_wrap();
    logic [TW-1:0] t;
    do_reset();
    rand_req_fields();
    t = req_tag_in[TW +: TW];
    req_valid_in = 2'b10;
    req_rw_in    = '0;
    #1;
    tests++;
    if (req_ready_in !== 2'b10) begin
      fails++;
      $display("FAIL wrap_grant got=%b exp=10", req_ready_in);
    end
    tick();
    tests++;
    if (req_valid_out !== 1'b1 || req_tag_out !== {t, 1'b1}) begin
      fails++;
      $display("FAIL wrap_tag valid=%b tag=%h exp valid=1 tag=%h", req_valid_out, req_tag_out, {t, 1'b1});
    end
    req_valid_in = '1;
    rand_req_fields();
    #1;
    tests++;
    if (req_ready_in !== 2'b01 || req_ready_in !== m_ready_in()) begin
      fails++;
      $display("FAIL wrap_ptr got=%b exp=01", req_ready_in);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [TOW-1:0]  held_tag;
    logic [L*AW-1:0] held_addr;
    logic [L*DW-1:0] held_data;
    do_reset();
    rand_req_fields();
    req_valid_in = 2'b01;
    req_rw_in    = 2'b00;
    held_tag  = {req_tag_in[0 +: TW], 1'b0};
    held_addr = req_addr_in[0 +: L*AW];
    held_data = req_data_in[0 +: L*DW];
    tick();
    req_ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid_in = '1;
      req_rw_in    = N'($urandom);
      rand_req_fields();
      #1;
      tests++;
      if (req_ready_in !== '0) begin
        fails++;
        $display("FAIL bp_ready_in cyc=%0d got=%b exp=00", k, req_ready_in);
      end
      tick();
      tests++;
      if (req_valid_out !== 1'b1 || req_tag_out !== held_tag || req_addr_out !== held_addr ||
          req_data_out !== held_data) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d valid=%b tag=%h exp valid=1 tag=%h", k, req_valid_out, req_tag_out, held_tag);
      end
    end
    req_ready_out = 1'b1;
    req_rw_in     = '0;
    rand_req_fields();
    #1;
    tests++;
    if (req_ready_in !== 2'b10) begin
      fails++;
      $display("FAIL bp_release_grant got=%b exp=10", req_ready_in);
    end
    tick();
    tests++;
    if (req_valid_out !== 1'b1 || req_tag_out !== e_tag || req_tag_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_out tag=%h exp=%h", req_tag_out, e_tag);
    end
  endtask

  task automatic test_throttle();
    do_reset();
    req_rw_in = '0;
    for (int k = 0; k < MP; k++) begin
      req_valid_in = 2'b01;
      rand_req_fields();
      #1;
      tests++;
      if (req_ready_in !== 2'b01) begin
        fails++;
        $display("FAIL thr_fill cyc=%0d got=%b exp=01", k, req_ready_in);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      req_valid_in = 2'b11;
      rand_req_fields();
      #1;
      tests++;
      if (req_ready_in !== 2'b10) begin
        fails++;
        $display("FAIL thr_skip cyc=%0d got=%b exp=10", k, req_ready_in);
      end
      tick();
    end
    req_valid_in  = 2'b01;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {TW'($urandom), 1'b0};
    rand_rsp_fields();
    #1;
    tests++;
    if (req_ready_in !== 2'b00 || rsp_ready_in !== 1'b1) begin
      fails++;
      $display("FAIL thr_stall got=%b rsp_ready_in=%b exp=00/1", req_ready_in, rsp_ready_in);
    end
    tick();
    rsp_valid_in = 1'b0;
    #1;
    tests++;
    if (rsp_valid_out !== 2'b01 || req_ready_in !== 2'b00) begin
      fails++;
      $display("FAIL thr_rsp rsp_valid_out=%b req_ready_in=%b exp=01/00", rsp_valid_out, req_ready_in);
    end
    tick();
    #1;
    tests++;
    if (req_ready_in !== 2'b01) begin
      fails++;
      $display("FAIL thr_resume got=%b exp=01", req_ready_in);
    end
    tick();
    tests++;
    if (req_valid_out !== 1'b1 || req_tag_out !== e_tag || req_tag_out[0] !== 1'b0) begin
      fails++;
      $display("FAIL thr_resume_out tag=%h exp=%h", req_tag_out, e_tag);
    end
  endtask

  task automatic test_rsp_hold();
    logic [TW-1:0]   t;
    logic [L*DW-1:0] d;
    do_reset();
    req_valid_in = 2'b10;
    req_rw_in    = '0;
    rand_req_fields();
    tick();
    req_valid_in  = '0;
    t             = TW'($urandom);
    rand_rsp_fields();
    d             = rsp_data_in;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {t, 1'b1};
    rsp_ready_out = 2'b01;
    tick();
    rsp_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (rsp_valid_out !== 2'b10 || rsp_ready_in !== 1'b0 || rsp_tag_out !== {t, t} ||
          rsp_data_out !== {d, d} || idle !== 1'b0) begin
        fails++;
        $display("FAIL rsp_hold cyc=%0d valid=%b ready_in=%b tag=%h idle=%b exp 10/0/%h/0",
                 k, rsp_valid_out, rsp_ready_in, rsp_tag_out, idle, {t, t});
      end
      tick();
    end
    rsp_ready_out = 2'b10;
    #1;
    tests++;
    if (rsp_ready_in !== 1'b1) begin
      fails++;
      $display("FAIL rsp_release_ready got=%b exp=1", rsp_ready_in);
    end
    tick();
    tests++;
    if (rsp_valid_out !== '0 || idle !== 1'b1 || idle !== m_idle()) begin
      fails++;
      $display("FAIL rsp_release_cnt valid=%b idle=%b exp 00/1", rsp_valid_out, idle);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid_in  = N'($urandom);
      req_rw_in     = N'($urandom);
      req_ready_out = ($urandom_range(0, 3) != 0);
      rsp_ready_out = N'($urandom);
      rand_req_fields();
      rand_rsp_fields();
      rsp_valid_in = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        int i, avail;
        i = $urandom_range(0, N - 1);
        avail = m_cnt[i] - ((e_sv && e_ssel == i) ? 1 : 0);
        if (avail > 0) begin
          rsp_valid_in = 1'b1;
          rsp_tag_in   = {TW'($urandom), SB'(i)};
        end
      end
      #1;
      tests++;
      if (req_ready_in !== m_ready_in() || rsp_ready_in !== (!e_sv || rsp_ready_out[e_ssel])) begin
        fails++;
        $display("FAIL rnd_ready cyc=%0d req_ready_in=%b exp=%b rsp_ready_in=%b", k, req_ready_in, m_ready_in(), rsp_ready_in);
      end
      tick();
      tests++;
      if (req_valid_out !== e_rv || (e_rv && ({req_rw_out, req_tmask_out, req_byteen_out, req_addr_out,
          req_data_out, req_tag_out} !== {e_rw, e_tmask, e_byteen, e_addr, e_data, e_tag}))) begin
        fails++;
        $display("FAIL rnd_req cyc=%0d valid=%b tag=%h exp valid=%b tag=%h", k, req_valid_out, req_tag_out, e_rv, e_tag);
      end
      tests++;
      if (rsp_valid_out !== m_rsp_valid() || (e_sv && ({rsp_tmask_out, rsp_data_out, rsp_tag_out} !==
          {{N{e_stmask}}, {N{e_sdata}}, {N{e_stag}}})) || idle !== m_idle()) begin
        fails++;
        $display("FAIL rnd_rsp cyc=%0d valid=%b exp=%b idle=%b exp=%b", k, rsp_valid_out, m_rsp_valid(), idle, m_idle());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_rw_in = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid_in = '1;
      rand_req_fields();
      tick();
    end
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {TW'($urandom), 1'b0};
    rsp_ready_out = '0;
    req_ready_out = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (req_valid_out !== 1'b0 || rsp_valid_out !== '0 || req_tag_out !== '0 ||
        rsp_tag_out !== '0 || idle !== 1'b1) begin
      fails++;
      $display("FAIL midrst_out req_valid=%b rsp_valid=%b idle=%b exp 0/00/1", req_valid_out, rsp_valid_out, idle);
    end
    do_reset();
    req_valid_in = '1;
    req_rw_in    = '0;
    #1;
    tests++;
    if (req_ready_in !== 2'b01) begin
      fails++;
      $display("FAIL midrst_first_grant got=%b exp=01", req_ready_in);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alternate();
    test_wrap();
    test_backpressure();
    test_throttle();
    test_rsp_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
